// File: rtl/vga_pkg.sv
// Shared VGA constants: active-area defaults, 3-bit {R,G,B} colours, motion FSM states.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        UPD_X,
        UPD_Y
    } motion_state_e;

    // Sprite colour sequence 1..7, skipping black so the sprite never disappears.
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == WHITE) ? BLUE : c + 3'd1;
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Sprite position/direction FSM: moves once per frame during vertical blanking.
module sprite_motion
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned SPEED    = 2,
    parameter int unsigned X_INIT   = 0,
    parameter int unsigned Y_INIT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       run,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] colour,
    output logic [7:0] bounce_count
);

    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SIZE);
    localparam logic [10:0] STEP  = 11'(SPEED);

    motion_state_e state_q, state_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic          dx_left_q, dx_left_d, dy_up_q, dy_up_d;
    logic          bounced_q, bounced_d;
    logic [2:0]    colour_q, colour_d;
    logic [7:0]    bc_q, bc_d;
    logic          hit_y;
    logic          frame_tick;

    assign frame_tick = pix_en && (h_counter == 10'd0) && (v_counter == 10'(V_ACTIVE));

    // Next-state and motion update; X then Y on consecutive pixel ticks.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_left_d = dx_left_q;
        dy_up_d   = dy_up_q;
        bounced_d = bounced_q;
        colour_d  = colour_q;
        bc_d      = bc_q;
        hit_y     = 1'b0;
        if (pix_en) begin
            case (state_q)
                WAIT_FRAME: begin
                    bounced_d = 1'b0;
                    if (frame_tick && run) state_d = UPD_X;
                end
                UPD_X: begin
                    if (!dx_left_q) begin
                        if (x_q + STEP > X_MAX) begin
                            x_d       = X_MAX;
                            dx_left_d = 1'b1;
                            bounced_d = 1'b1;
                        end else begin
                            x_d = x_q + STEP;
                        end
                    end else begin
                        if (x_q < STEP) begin
                            x_d       = '0;
                            dx_left_d = 1'b0;
                            bounced_d = 1'b1;
                        end else begin
                            x_d = x_q - STEP;
                        end
                    end
                    state_d = UPD_Y;
                end
                UPD_Y: begin
                    if (!dy_up_q) begin
                        if (y_q + STEP > Y_MAX) begin
                            y_d     = Y_MAX;
                            dy_up_d = 1'b1;
                            hit_y   = 1'b1;
                        end else begin
                            y_d = y_q + STEP;
                        end
                    end else begin
                        if (y_q < STEP) begin
                            y_d     = '0;
                            dy_up_d = 1'b0;
                            hit_y   = 1'b1;
                        end else begin
                            y_d = y_q - STEP;
                        end
                    end
                    // A corner hit sets both flags but still counts once.
                    if (bounced_q || hit_y) begin
                        bc_d     = bc_q + 8'd1;
                        colour_d = next_colour(colour_q);
                    end
                    state_d = WAIT_FRAME;
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    // Motion state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_FRAME;
            x_q       <= 11'(X_INIT);
            y_q       <= 11'(Y_INIT);
            dx_left_q <= 1'b0;
            dy_up_q   <= 1'b0;
            bounced_q <= 1'b0;
            colour_q  <= RED;
            bc_q      <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_left_q <= dx_left_d;
            dy_up_q   <= dy_up_d;
            bounced_q <= bounced_d;
            colour_q  <= colour_d;
            bc_q      <= bc_d;
        end
    end

    assign x            = x_q[9:0];
    assign y            = y_q[9:0];
    assign colour       = colour_q;
    assign bounce_count = bc_q;

endmodule

// File: rtl/bounce_sprite_gen.sv
// Bouncing-sprite pixel generator: 2-stage colour pipeline with matched sync delay.
module bounce_sprite_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned SIZE         = 32,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned X_INIT       = 0,
    parameter int unsigned Y_INIT       = 0,
    parameter int unsigned BORDER_W     = 4,
    parameter logic [2:0]  BG_COLOR     = BLUE,
    parameter logic [2:0]  BORDER_COLOR = WHITE
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       pix_en,
    input  logic       run,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [2:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       bright_out,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [7:0] bounce_count
);

    localparam logic [10:0] SIZE_W = 11'(SIZE);
    localparam logic [10:0] BW     = 11'(BORDER_W);
    localparam logic [10:0] H_BR   = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0] V_BR   = 11'(V_ACTIVE - BORDER_W);

    logic [9:0]  spr_x, spr_y;
    logic [2:0]  spr_colour;
    logic [10:0] h_w, v_w, x_w, y_w;

    logic       in_spr_q, in_spr_d, in_bord_q, in_bord_d, vis_q, vis_d;
    logic       hs1_q, hs1_d, vs1_q, vs1_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hs2_q, hs2_d, vs2_q, vs2_d, bright_q, bright_d;

    sprite_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SIZE     (SIZE),
        .SPEED    (SPEED),
        .X_INIT   (X_INIT),
        .Y_INIT   (Y_INIT)
    ) u_motion (
        .clk          (clk),
        .rst_n        (clear),
        .pix_en       (pix_en),
        .run          (run),
        .h_counter    (h_counter),
        .v_counter    (v_counter),
        .x            (spr_x),
        .y            (spr_y),
        .colour       (spr_colour),
        .bounce_count (bounce_count)
    );

    assign h_w = {1'b0, h_counter};
    assign v_w = {1'b0, v_counter};
    assign x_w = {1'b0, spr_x};
    assign y_w = {1'b0, spr_y};

    // Stage 1: classify the incoming pixel and capture sync.
    always_comb begin
        in_spr_d  = in_spr_q;
        in_bord_d = in_bord_q;
        vis_d     = vis_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        if (pix_en) begin
            in_spr_d  = display_on && (h_w >= x_w) && (h_w < x_w + SIZE_W)
                                   && (v_w >= y_w) && (v_w < y_w + SIZE_W);
            in_bord_d = display_on && ((h_w < BW) || (h_w >= H_BR)
                                   ||  (v_w < BW) || (v_w >= V_BR));
            vis_d     = display_on;
            hs1_d     = hsync_in;
            vs1_d     = vsync_in;
        end
    end

    // Stage 2: colour priority sprite > border > background, blank outside display.
    always_comb begin
        rgb_d    = rgb_q;
        hs2_d    = hs2_q;
        vs2_d    = vs2_q;
        bright_d = bright_q;
        if (pix_en) begin
            if (!vis_q)         rgb_d = BLACK;
            else if (in_spr_q)  rgb_d = spr_colour;
            else if (in_bord_q) rgb_d = BORDER_COLOR;
            else                rgb_d = BG_COLOR;
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            bright_d = vis_q;
        end
    end

    // Pipeline registers; syncs reset to their inactive (high) level.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            in_spr_q  <= 1'b0;
            in_bord_q <= 1'b0;
            vis_q     <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb_q     <= BLACK;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            bright_q  <= 1'b0;
        end else begin
            in_spr_q  <= in_spr_d;
            in_bord_q <= in_bord_d;
            vis_q     <= vis_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            rgb_q     <= rgb_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            bright_q  <= bright_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign bright_out = bright_q;
    assign sprite_x   = spr_x;
    assign sprite_y   = spr_y;

endmodule

// File: tb/tb_bounce_sprite_gen.sv
// Scoreboard bench for bounce_sprite_gen: expectations are queued with the pix_en
// tick at which they become due; a monitor compares them on the falling clock edge.
module tb_bounce_sprite_gen;

    localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_BR = 3, S_X = 4, S_Y = 5, S_BC = 6;

    typedef struct {
        string name;
        int    inst;
        int    sig;
        int    exp;
        int    due;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       clear, pix_en, run, run_p, run_c;
    logic [9:0] h_counter, v_counter;
    logic       display_on, hsync_in, vsync_in;

    logic [2:0] rgb0, rgb1, rgb2;
    logic       hs0, hs1, hs2, vs0, vs1, vs2, br0, br1, br2;
    logic [9:0] x0, x1, x2, y0, y1, y2;
    logic [7:0] bc0, bc1, bc2;

    exp_t sb[$];
    int   ticks = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    event chk_now;

    bounce_sprite_gen dut (
        .clk(clk), .clear(clear), .pix_en(pix_en), .run(run),
        .h_counter(h_counter), .v_counter(v_counter), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb(rgb0), .hsync_out(hs0), .vsync_out(vs0), .bright_out(br0),
        .sprite_x(x0), .sprite_y(y0), .bounce_count(bc0)
    );

    bounce_sprite_gen #(.X_INIT(100), .Y_INIT(50)) dut_p (
        .clk(clk), .clear(clear), .pix_en(pix_en), .run(run_p),
        .h_counter(h_counter), .v_counter(v_counter), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb(rgb1), .hsync_out(hs1), .vsync_out(vs1), .bright_out(br1),
        .sprite_x(x1), .sprite_y(y1), .bounce_count(bc1)
    );

    bounce_sprite_gen #(.X_INIT(607), .Y_INIT(447)) dut_c (
        .clk(clk), .clear(clear), .pix_en(pix_en), .run(run_c),
        .h_counter(h_counter), .v_counter(v_counter), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb(rgb2), .hsync_out(hs2), .vsync_out(vs2), .bright_out(br2),
        .sprite_x(x2), .sprite_y(y2), .bounce_count(bc2)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) if (pix_en) ticks <= ticks + 1;

    function automatic int actual(input int inst, input int sig);
        logic [2:0] r;
        logic       hs, vs, br;
        logic [9:0] x, y;
        logic [7:0] bc;
        case (inst)
            0:       begin r = rgb0; hs = hs0; vs = vs0; br = br0; x = x0; y = y0; bc = bc0; end
            1:       begin r = rgb1; hs = hs1; vs = vs1; br = br1; x = x1; y = y1; bc = bc1; end
            default: begin r = rgb2; hs = hs2; vs = vs2; br = br2; x = x2; y = y2; bc = bc2; end
        endcase
        case (sig)
            S_RGB:   return int'(r);
            S_HS:    return int'(hs);
            S_VS:    return int'(vs);
            S_BR:    return int'(br);
            S_X:     return int'(x);
            S_Y:     return int'(y);
            default: return int'(bc);
        endcase
    endfunction

    // Monitor: pop and compare every expectation whose tick has been reached.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0 && sb[0].due <= ticks) begin
                e = sb.pop_front();
                a = actual(e.inst, e.sig);
                n_cmp++;
                if (a != e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, a, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_at(input string nm, input int inst, input int sig, input int exp, input int due);
        exp_t e;
        e.name = nm; e.inst = inst; e.sig = sig; e.exp = exp; e.due = due;
        sb.push_back(e);
    endtask

    task automatic step(input logic pe, input int h, input int v, input logic de,
                        input logic hs, input logic vs);
        pix_en     = pe;
        h_counter  = 10'(h);
        v_counter  = 10'(v);
        display_on = de;
        hsync_in   = hs;
        vsync_in   = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1, 479, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic frame();
        step(1'b1, 0, 480, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 480, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic pos(input string nm, input int inst, input int x, input int y, input int bc);
        expect_at({nm, "_x"}, inst, S_X, x, ticks);
        expect_at({nm, "_y"}, inst, S_Y, y, ticks);
        expect_at({nm, "_bc"}, inst, S_BC, bc, ticks);
    endtask

    task automatic pix_chk(input string nm, input int inst, input int h, input int v,
                           input logic de, input int exp);
        expect_at(nm, inst, S_RGB, exp, ticks + 2);
        step(1'b1, h, v, de, 1'b1, 1'b1);
        idle(2);
    endtask

    initial begin
        int c;
        clear = 1'b0; run = 1'b0; run_p = 1'b0; run_c = 1'b0;
        pix_en = 1'b0; h_counter = '0; v_counter = '0;
        display_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

        // Reset state
        idle(3);
        n_cmp++;
        if (rgb0 !== 3'b000) begin n_err++; $display("FAIL d_rst_rgb: got %0d", rgb0); end
        n_cmp++;
        if (br0 !== 1'b0) begin n_err++; $display("FAIL d_rst_br: got %0d", br0); end
        n_cmp++;
        if (x1 !== 10'd100) begin n_err++; $display("FAIL d_rst_x_p: got %0d", x1); end
        n_cmp++;
        if (bc0 !== 8'd0) begin n_err++; $display("FAIL d_rst_bc: got %0d", bc0); end
        expect_at("rst_rgb", 0, S_RGB, 0, ticks);
        expect_at("rst_hs", 0, S_HS, 1, ticks);
        expect_at("rst_vs", 0, S_VS, 1, ticks);
        expect_at("rst_br", 0, S_BR, 0, ticks);
        pos("rst", 0, 0, 0, 0);
        pos("rst_p", 1, 100, 50, 0);
        pos("rst_c", 2, 607, 447, 0);
        idle(1);
        clear = 1'b1;
        idle(3);
        expect_at("blank_rgb", 0, S_RGB, 0, ticks);
        expect_at("blank_br", 0, S_BR, 0, ticks);
        idle(1);

        // First frame: x moves at tick+2, y and count at tick+3; corner instance hits both walls
        run = 1'b1; run_c = 1'b1;
        c = ticks;
        expect_at("f1_x_t1", 0, S_X, 0, c + 1);
        expect_at("f1_x_t2", 0, S_X, 2, c + 2);
        expect_at("f1_y_t2", 0, S_Y, 0, c + 2);
        expect_at("f1_y_t3", 0, S_Y, 2, c + 3);
        expect_at("f1_bc_t3", 0, S_BC, 0, c + 3);
        frame();
        run_c = 1'b0;
        pos("corner", 2, 608, 448, 1);
        pix_chk("corner_col", 2, 610, 450, 1'b1, 5);

        // Frozen for three frames
        run = 1'b0;
        for (int i = 0; i < 3; i++) frame();
        pos("frozen", 0, 2, 2, 0);
        pos("frozen_p", 1, 100, 50, 0);

        // Pixel pipeline on the parked sprite at (100,50)
        pix_chk("spr_tl", 1, 100, 50, 1'b1, 4);
        pix_chk("spr_br", 1, 131, 81, 1'b1, 4);
        pix_chk("bg_left", 1, 99, 50, 1'b1, 1);
        pix_chk("bg_right", 1, 132, 50, 1'b1, 1);
        pix_chk("bg_above", 1, 100, 49, 1'b1, 1);
        pix_chk("border_l", 1, 2, 200, 1'b1, 7);
        pix_chk("border_br", 1, 639, 479, 1'b1, 7);
        pix_chk("not_vis", 1, 100, 50, 1'b0, 0);

        // Sync delay
        c = ticks;
        expect_at("hs_low", 1, S_HS, 0, c + 2);
        expect_at("br_high", 1, S_BR, 1, c + 2);
        expect_at("hs_back", 1, S_HS, 1, c + 3);
        expect_at("vs_low", 1, S_VS, 0, c + 3);
        step(1'b1, 5, 100, 1'b1, 1'b0, 1'b1);
        step(1'b1, 5, 100, 1'b1, 1'b1, 1'b0);
        idle(3);

        // pix_en gaps hold everything
        c = ticks;
        expect_at("gap_a", 1, S_RGB, 4, c + 2);
        step(1'b1, 100, 50, 1'b1, 1'b1, 1'b1);
        step(1'b1, 2, 200, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_at("gap_hold_rgb", 1, S_RGB, 4, ticks);
            expect_at("gap_hold_hs", 1, S_HS, 1, ticks);
            step(1'b0, 300, 300, 1'b0, 1'b0, 1'b0);
        end
        expect_at("gap_b", 1, S_RGB, 7, ticks + 1);
        idle(3);

        // Long run through seven bounces
        run = 1'b1;
        for (int n = 2; n <= 915; n++) begin
            frame();
            case (n)
                224: pos("f224", 0, 448, 448, 0);
                225: begin pos("f225", 0, 450, 448, 1); pix_chk("col_b1", 0, 451, 449, 1'b1, 5); end
                226: pos("f226", 0, 452, 446, 1);
                304: pos("f304", 0, 608, 290, 1);
                305: pos("f305", 0, 608, 288, 2);
                306: pos("f306", 0, 606, 286, 2);
                449: pos("f449", 0, 320, 0, 2);
                450: begin pos("f450", 0, 318, 0, 3); pix_chk("col_b3", 0, 320, 10, 1'b1, 7); end
                610: pos("f610", 0, 0, 320, 4);
                675: begin pos("f675", 0, 130, 448, 5); pix_chk("col_b5", 0, 131, 449, 1'b1, 2); end
                900: pos("f900", 0, 580, 0, 6);
                915: begin pos("f915", 0, 608, 30, 7); pix_chk("col_b7", 0, 609, 31, 1'b1, 4); end
                default: ;
            endcase
        end
        pos("end_p", 1, 100, 50, 0);
        pos("end_c", 2, 608, 448, 1);

        // Asynchronous reset mid-update with the clock stopped
        step(1'b1, 0, 480, 1'b0, 1'b1, 1'b1);
        step(1'b1, 609, 31, 1'b1, 1'b0, 1'b0);
        step(1'b1, 609, 31, 1'b1, 1'b0, 1'b0);
        expect_at("pre_rst_rgb", 0, S_RGB, 4, ticks);
        expect_at("pre_rst_hs", 0, S_HS, 0, ticks);
        expect_at("pre_rst_x", 0, S_X, 606, ticks);
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        #3;
        clear = 1'b0;
        #2;
        n_cmp++;
        if (rgb0 !== 3'b000) begin n_err++; $display("FAIL d_arst_rgb: got %0d", rgb0); end
        n_cmp++;
        if (hs0 !== 1'b1) begin n_err++; $display("FAIL d_arst_hs: got %0d", hs0); end
        n_cmp++;
        if (vs0 !== 1'b1) begin n_err++; $display("FAIL d_arst_vs: got %0d", vs0); end
        n_cmp++;
        if (x0 !== 10'd0) begin n_err++; $display("FAIL d_arst_x: got %0d", x0); end
        expect_at("arst_rgb", 0, S_RGB, 0, ticks);
        expect_at("arst_hs", 0, S_HS, 1, ticks);
        expect_at("arst_vs", 0, S_VS, 1, ticks);
        expect_at("arst_br", 0, S_BR, 0, ticks);
        pos("arst", 0, 0, 0, 0);
        ->chk_now;
        #2;
        clk_run = 1'b1;
        idle(2);
        clear = 1'b1;
        idle(4);
        pos("post_rst_idle", 0, 0, 0, 0);
        c = ticks;
        expect_at("post_rst_x1", 0, S_X, 0, c + 1);
        expect_at("post_rst_x2", 0, S_X, 2, c + 2);
        expect_at("post_rst_y3", 0, S_Y, 2, c + 3);
        frame();
        idle(3);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: never checked, expected %0d", e.name, e.exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
